beta_trap_ctrl: RTL and testbench

- Trap control unit (TCU) at the commit point of the core.
- Consumes the per-stage trap codes from the fetch/decode (INSTR_*), LSU (LSU_*) and sync-event (SYNC_*) encodings of beta_trap_pkg, plus three machine interrupt lines.
- Arbitrates them, owns the machine trap CSRs, and drives a held PC-redirect/flush handshake toward fetch.
- Classifies each trap as TCU_NOTRAP/TCU_INTERRUPT/TCU_EXCEPTION using the package cause enums.

---
 rtl/beta_trap_ctrl_if.sv | 38 +++
 rtl/beta_trap_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_beta_trap_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/beta_trap_ctrl_if.sv
// Commit/CSR/redirect bundle between the core commit stage and the trap control unit.
interface beta_trap_ctrl_if;
  logic        valid_i;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic [31:0] fault_addr_i;
  logic [1:0]  instr_trap_i;
  logic [1:0]  lsu_trap_i;
  logic [1:0]  sync_trap_i;
  logic        irq_sw_i;
  logic        irq_timer_i;
  logic        irq_ext_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;
  logic        stall_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ack_i;
  logic [1:0]  trap_type_o;

  // Core side: drives commit info, CSR access and the redirect ack.
  modport master (
    output valid_i, pc_i, instr_i, fault_addr_i, instr_trap_i, lsu_trap_i, sync_trap_i,
           irq_sw_i, irq_timer_i, irq_ext_i, csr_we_i, csr_addr_i, csr_wdata_i, redirect_ack_i,
    input  csr_rdata_o, csr_hit_o, stall_o, flush_o, redirect_o, redirect_pc_o, trap_type_o
  );

  // Trap control unit side.
  modport slave (
    input  valid_i, pc_i, instr_i, fault_addr_i, instr_trap_i, lsu_trap_i, sync_trap_i,
           irq_sw_i, irq_timer_i, irq_ext_i, csr_we_i, csr_addr_i, csr_wdata_i, redirect_ack_i,
    output csr_rdata_o, csr_hit_o, stall_o, flush_o, redirect_o, redirect_pc_o, trap_type_o
  );
endinterface

// File: rtl/beta_trap_ctrl.sv
// Trap control unit: arbitrates commit-point traps and interrupts, owns the
// machine trap CSRs and drives a held redirect/flush handshake toward fetch.
package beta_trap_pkg;
  localparam logic [1:0] INSTR_NOTRAP        = 2'd0;
  localparam logic [1:0] INSTR_MISALIG_FETCH = 2'd1;
  localparam logic [1:0] INSTR_ILLEGAL_FETCH = 2'd2;

  localparam logic [1:0] LSU_NOTRAP          = 2'd0;
  localparam logic [1:0] LSU_MISALIG_LOAD    = 2'd1;
  localparam logic [1:0] LSU_MISALIG_STORE   = 2'd2;

  localparam logic [1:0] SYNC_NOTRAP         = 2'd0;
  localparam logic [1:0] SYNC_ECALL          = 2'd1;
  localparam logic [1:0] SYNC_MRET           = 2'd2;

  localparam logic [1:0] TCU_NOTRAP          = 2'd0;
  localparam logic [1:0] TCU_INTERRUPT       = 2'd1;
  localparam logic [1:0] TCU_EXCEPTION       = 2'd2;

  // bit4 flags an interrupt, bits[3:0] are the architectural cause code
  typedef enum logic [4:0] {
    INSTR_MISALIGNED = 5'h00,
    INSTR_ILLEGAL    = 5'h02,
    LOAD_MISALIGNED  = 5'h04,
    STORE_MISALIGNED = 5'h06,
    ENV_CALL_MMODE   = 5'h0B,
    MSW_INT          = 5'h13,
    MTIM_INT         = 5'h17,
    MEXT_INT         = 5'h1B
  } cause_e;
endpackage

module beta_trap_ctrl
  import beta_trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  beta_trap_ctrl_if.slave  bus
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] TRAP  = 2'd1;
  localparam logic [1:0] REDIR = 2'd2;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Only MODE 00/01 are representable; MODE is hardwired to 00 without vectoring.
  function automatic logic [31:0] mtvec_legal(input logic [31:0] w);
    if (VECTORED_EN) mtvec_legal = {w[31:2], 1'b0, w[0]};
    else             mtvec_legal = {w[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] mcause_of(input cause_e c);
    mcause_of = {c[4], 27'b0, c[3:0]};
  endfunction

  // Vectored dispatch applies to interrupts only; exceptions always go to the base.
  function automatic logic [31:0] trap_target(input logic [31:0] tvec, input cause_e c);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if (VECTORED_EN && (tvec[1:0] == 2'b01) && c[4])
      trap_target = base + {26'b0, c[3:0], 2'b00};
    else
      trap_target = base;
  endfunction

  logic [1:0]  state;
  logic        mstatus_mie, mstatus_mpie;
  logic        mie_sw, mie_tim, mie_ext;
  logic [31:0] mtvec_r, mepc_r, mcause_r, mtval_r;

  cause_e      cause_p1;
  logic [31:0] tval_p1;
  logic [31:0] pc_p1;
  logic        mret_p1;

  logic [31:0] target_p2;
  logic [1:0]  trap_type_p2;

  logic        ev_trap, ev_mret;
  cause_e      ev_cause;
  logic [31:0] ev_tval;
  logic        csr_wr;

  // Pick the highest-priority event at commit; only looked at in RUN with a valid instruction.
  always_comb begin
    ev_trap  = 1'b0;
    ev_mret  = 1'b0;
    ev_cause = INSTR_MISALIGNED;
    ev_tval  = 32'h0;
    if (state == RUN && bus.valid_i) begin
      if (bus.irq_ext_i && mie_ext && mstatus_mie) begin
        ev_trap  = 1'b1;
        ev_cause = MEXT_INT;
      end else if (bus.irq_sw_i && mie_sw && mstatus_mie) begin
        ev_trap  = 1'b1;
        ev_cause = MSW_INT;
      end else if (bus.irq_timer_i && mie_tim && mstatus_mie) begin
        ev_trap  = 1'b1;
        ev_cause = MTIM_INT;
      end else if (bus.instr_trap_i == INSTR_MISALIG_FETCH) begin
        ev_trap  = 1'b1;
        ev_cause = INSTR_MISALIGNED;
        ev_tval  = bus.fault_addr_i;
      end else if (bus.instr_trap_i == INSTR_ILLEGAL_FETCH) begin
        ev_trap  = 1'b1;
        ev_cause = INSTR_ILLEGAL;
        ev_tval  = bus.instr_i;
      end else if (bus.sync_trap_i == SYNC_ECALL) begin
        ev_trap  = 1'b1;
        ev_cause = ENV_CALL_MMODE;
      end else if (bus.lsu_trap_i == LSU_MISALIG_LOAD) begin
        ev_trap  = 1'b1;
        ev_cause = LOAD_MISALIGNED;
        ev_tval  = bus.fault_addr_i;
      end else if (bus.lsu_trap_i == LSU_MISALIG_STORE) begin
        ev_trap  = 1'b1;
        ev_cause = STORE_MISALIGNED;
        ev_tval  = bus.fault_addr_i;
      end else if (bus.sync_trap_i == SYNC_MRET) begin
        ev_mret  = 1'b1;
      end
    end
  end

  // A committing instruction that traps (or returns) must not also write a CSR.
  assign csr_wr = (state == RUN) && bus.csr_we_i && !ev_trap && !ev_mret;

  // Control FSM: RUN -> TRAP -> REDIR -> RUN on fetch ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (ev_trap || ev_mret) state <= TRAP;
        TRAP:    state <= REDIR;
        REDIR:   if (bus.redirect_ack_i) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // ---- stage p0 -> p1: hold the event details for the CSR update cycle ----
  always_ff @(posedge clk_i) begin
    if (state == RUN && (ev_trap || ev_mret)) begin
      cause_p1 <= ev_cause;
      tval_p1  <= ev_tval;
      pc_p1    <= bus.pc_i;
      mret_p1  <= ev_mret;
    end
  end

  // Machine CSR file: trap/return side effects in TRAP, software writes in RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_sw       <= 1'b0;
      mie_tim      <= 1'b0;
      mie_ext      <= 1'b0;
      mtvec_r      <= mtvec_legal(MTVEC_RESET);
      mepc_r       <= 32'h0;
      mcause_r     <= 32'h0;
      mtval_r      <= 32'h0;
    end else if (state == TRAP) begin
      if (mret_p1) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else begin
        mepc_r       <= pc_p1;
        mcause_r     <= mcause_of(cause_p1);
        mtval_r      <= tval_p1;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end
    end else if (csr_wr) begin
      case (bus.csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_mie  <= bus.csr_wdata_i[3];
          mstatus_mpie <= bus.csr_wdata_i[7];
        end
        CSR_MIE: begin
          mie_sw  <= bus.csr_wdata_i[3];
          mie_tim <= bus.csr_wdata_i[7];
          mie_ext <= bus.csr_wdata_i[11];
        end
        CSR_MTVEC:  mtvec_r  <= mtvec_legal(bus.csr_wdata_i);
        CSR_MEPC:   mepc_r   <= {bus.csr_wdata_i[31:2], 2'b00};
        CSR_MCAUSE: mcause_r <= bus.csr_wdata_i;
        CSR_MTVAL:  mtval_r  <= bus.csr_wdata_i;
        default: ;
      endcase
    end
  end

  // ---- stage p1 -> p2: redirect target and trap class, held through REDIR ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      target_p2    <= 32'h0;
      trap_type_p2 <= TCU_NOTRAP;
    end else if (state == TRAP) begin
      if (mret_p1) begin
        target_p2    <= mepc_r;
        trap_type_p2 <= TCU_NOTRAP;
      end else begin
        target_p2    <= trap_target(mtvec_r, cause_p1);
        trap_type_p2 <= cause_p1[4] ? TCU_INTERRUPT : TCU_EXCEPTION;
      end
    end else if (state == REDIR && bus.redirect_ack_i) begin
      trap_type_p2 <= TCU_NOTRAP;
    end
  end

  // Combinational CSR read port.
  always_comb begin
    bus.csr_rdata_o = 32'h0;
    bus.csr_hit_o   = 1'b1;
    case (bus.csr_addr_i)
      CSR_MSTATUS: bus.csr_rdata_o = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      CSR_MIE:     bus.csr_rdata_o = {20'b0, mie_ext, 3'b0, mie_tim, 3'b0, mie_sw, 3'b0};
      CSR_MTVEC:   bus.csr_rdata_o = mtvec_r;
      CSR_MEPC:    bus.csr_rdata_o = mepc_r;
      CSR_MCAUSE:  bus.csr_rdata_o = mcause_r;
      CSR_MTVAL:   bus.csr_rdata_o = mtval_r;
      CSR_MIP:     bus.csr_rdata_o = {20'b0, bus.irq_ext_i, 3'b0, bus.irq_timer_i, 3'b0, bus.irq_sw_i, 3'b0};
      default:     bus.csr_hit_o   = 1'b0;
    endcase
  end

  // Handshake outputs; stall also covers the commit cycle in which an event is taken.
  always_comb begin
    bus.stall_o       = (state != RUN) || ev_trap || ev_mret;
    bus.flush_o       = (state == REDIR);
    bus.redirect_o    = (state == REDIR);
    bus.redirect_pc_o = target_p2;
    bus.trap_type_o   = trap_type_p2;
  end

endmodule

// File: tb/tb_beta_trap_ctrl.sv
// Directed bench for beta_trap_ctrl: traps, interrupts, mret, held redirect, reset abort.
module tb_beta_trap_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] rd;

  beta_trap_ctrl_if bus ();

  beta_trap_ctrl #(.MTVEC_RESET(32'h0), .VECTORED_EN(1'b1)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.valid_i = 1'b0; bus.pc_i = '0; bus.instr_i = '0; bus.fault_addr_i = '0;
    bus.instr_trap_i = 2'd0; bus.lsu_trap_i = 2'd0; bus.sync_trap_i = 2'd0;
    bus.irq_sw_i = 1'b0; bus.irq_timer_i = 1'b0; bus.irq_ext_i = 1'b0;
    bus.csr_we_i = 1'b0; bus.csr_wdata_i = '0; bus.redirect_ack_i = 1'b0;
  endtask

  task automatic write_csr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we_i = 1'b1; bus.csr_addr_i = a; bus.csr_wdata_i = d;
    tick();
    bus.csr_we_i = 1'b0;
  endtask

  task automatic read_csr(input logic [11:0] a, output logic [31:0] d);
    bus.csr_addr_i = a;
    #1;
    d = bus.csr_rdata_o;
  endtask

  // Present one commit-cycle event, then step to the first REDIR cycle.
  task automatic run_event(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] fa,
                           input logic [1:0] it, input logic [1:0] lt, input logic [1:0] st,
                           input logic sw, input logic tim, input logic ext);
    bus.valid_i = 1'b1; bus.pc_i = pc; bus.instr_i = instr; bus.fault_addr_i = fa;
    bus.instr_trap_i = it; bus.lsu_trap_i = lt; bus.sync_trap_i = st;
    bus.irq_sw_i = sw; bus.irq_timer_i = tim; bus.irq_ext_i = ext;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic ack();
    bus.redirect_ack_i = 1'b1;
    tick();
    bus.redirect_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.csr_addr_i = 12'h0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL rst_redirect got=%0h exp=0", bus.redirect_o); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL rst_flush got=%0h exp=0", bus.flush_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0h exp=0", bus.stall_o); end
    checks++; if (bus.trap_type_o !== 2'd0) begin errors++; $display("FAIL rst_type got=%0h exp=0", bus.trap_type_o); end
    read_csr(12'h300, rd);
    checks++; if (rd !== 32'h0000_1800) begin errors++; $display("FAIL rst_mstatus got=%h exp=00001800", rd); end
    read_csr(12'h305, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mtvec got=%h exp=00000000", rd); end
    read_csr(12'h342, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mcause got=%h exp=00000000", rd); end
    read_csr(12'h123, rd);
    checks++; if (bus.csr_hit_o !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL unowned_read hit=%0h data=%h exp hit=0 data=0", bus.csr_hit_o, rd); end
    bus.irq_sw_i = 1'b1;
    read_csr(12'h344, rd);
    checks++; if (rd !== 32'h8 || bus.csr_hit_o !== 1'b1) begin errors++; $display("FAIL mip_read got=%h hit=%0h exp=00000008 hit=1", rd, bus.csr_hit_o); end
    bus.irq_sw_i = 1'b0;
  endtask

  task automatic test_illegal();
    write_csr(12'h305, 32'h100);
    write_csr(12'h300, 32'h8);
    bus.valid_i = 1'b1; bus.pc_i = 32'h2004; bus.instr_i = 32'hFFFF_FFFF; bus.instr_trap_i = 2'd2;
    #1;
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL ill_stall_commit got=%0h exp=1", bus.stall_o); end
    tick();
    clear_inputs();
    checks++; if (bus.redirect_o !== 1'b0 || bus.stall_o !== 1'b1) begin errors++; $display("FAIL ill_trap_cycle redir=%0h stall=%0h exp redir=0 stall=1", bus.redirect_o, bus.stall_o); end
    tick();
    checks++; if (bus.redirect_o !== 1'b1 || bus.flush_o !== 1'b1) begin errors++; $display("FAIL ill_redirect redir=%0h flush=%0h exp 1 1", bus.redirect_o, bus.flush_o); end
    checks++; if (bus.redirect_pc_o !== 32'h100) begin errors++; $display("FAIL ill_target got=%h exp=00000100", bus.redirect_pc_o); end
    checks++; if (bus.trap_type_o !== 2'd2) begin errors++; $display("FAIL ill_type got=%0h exp=2", bus.trap_type_o); end
    ack();
    checks++; if (bus.redirect_o !== 1'b0 || bus.flush_o !== 1'b0 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL ill_release redir=%0h flush=%0h stall=%0h exp 0 0 0", bus.redirect_o, bus.flush_o, bus.stall_o); end
    checks++; if (bus.trap_type_o !== 2'd0) begin errors++; $display("FAIL ill_type_clear got=%0h exp=0", bus.trap_type_o); end
    read_csr(12'h341, rd);
    checks++; if (rd !== 32'h2004) begin errors++; $display("FAIL ill_mepc got=%h exp=00002004", rd); end
    read_csr(12'h342, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL ill_mcause got=%h exp=00000002", rd); end
    read_csr(12'h343, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ill_mtval got=%h exp=ffffffff", rd); end
    read_csr(12'h300, rd);
    checks++; if (rd !== 32'h0000_1880) begin errors++; $display("FAIL ill_mstatus got=%h exp=00001880", rd); end
  endtask

  task automatic test_irq();
    write_csr(12'h304, 32'hFFFF_FFFF);
    read_csr(12'h304, rd);
    checks++; if (rd !== 32'h888) begin errors++; $display("FAIL mie_mask got=%h exp=00000888", rd); end
    write_csr(12'h305, 32'h201);
    write_csr(12'h300, 32'h8);
    run_event(32'h4000, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.redirect_pc_o !== 32'h22C) begin errors++; $display("FAIL irq_ext_target got=%h exp=0000022c", bus.redirect_pc_o); end
    checks++; if (bus.trap_type_o !== 2'd1) begin errors++; $display("FAIL irq_ext_type got=%0h exp=1", bus.trap_type_o); end
    ack();
    read_csr(12'h342, rd);
    checks++; if (rd !== 32'h8000_000B) begin errors++; $display("FAIL irq_ext_mcause got=%h exp=8000000b", rd); end
    read_csr(12'h343, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irq_ext_mtval got=%h exp=00000000", rd); end
    read_csr(12'h341, rd);
    checks++; if (rd !== 32'h4000) begin errors++; $display("FAIL irq_ext_mepc got=%h exp=00004000", rd); end
    // with MIE cleared by the trap, a pending irq alone must not trap again
    bus.valid_i = 1'b1; bus.irq_timer_i = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL irq_masked_stall got=%0h exp=0", bus.stall_o); end
    clear_inputs();
    write_csr(12'h300, 32'h8);
    run_event(32'h4100, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.redirect_pc_o !== 32'h21C) begin errors++; $display("FAIL irq_tim_target got=%h exp=0000021c", bus.redirect_pc_o); end
    ack();
    read_csr(12'h342, rd);
    checks++; if (rd !== 32'h8000_0007) begin errors++; $display("FAIL irq_tim_mcause got=%h exp=80000007", rd); end
    write_csr(12'h300, 32'h8);
    run_event(32'h4200, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    ack();
    read_csr(12'h342, rd);
    checks++; if (rd !== 32'h8000_0003) begin errors++; $display("FAIL irq_sw_over_tim got=%h exp=80000003", rd); end
  endtask

  task automatic test_priority();
    run_event(32'h5000, 32'h0, 32'h1002, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.redirect_pc_o !== 32'h200) begin errors++; $display("FAIL misfetch_target got=%h exp=00000200", bus.redirect_pc_o); end
    checks++; if (bus.trap_type_o !== 2'd2) begin errors++; $display("FAIL misfetch_type got=%0h exp=2", bus.trap_type_o); end
    ack();
    read_csr(12'h342, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misfetch_mcause got=%h exp=00000000", rd); end
    read_csr(12'h343, rd);
    checks++; if (rd !== 32'h1002) begin errors++; $display("FAIL misfetch_mtval got=%h exp=00001002", rd); end
    run_event(32'h5004, 32'h0, 32'h2222, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    ack();
    read_csr(12'h342, rd);
    checks++; if (rd !== 32'hB) begin errors++; $display("FAIL ecall_mcause got=%h exp=0000000b", rd); end
    read_csr(12'h343, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ecall_mtval got=%h exp=00000000", rd); end
    run_event(32'h5008, 32'h0, 32'h777, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    ack();
    read_csr(12'h342, rd);
    checks++; if (rd !== 32'h6) begin errors++; $display("FAIL store_mcause got=%h exp=00000006", rd); end
    read_csr(12'h343, rd);
    checks++; if (rd !== 32'h777) begin errors++; $display("FAIL store_mtval got=%h exp=00000777", rd); end
  endtask

  task automatic test_mret();
    write_csr(12'h300, 32'h80);
    write_csr(12'h341, 32'h3000);
    run_event(32'h6000, 32'h0, 32'h0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.redirect_pc_o !== 32'h3000) begin errors++; $display("FAIL mret_target got=%h exp=00003000", bus.redirect_pc_o); end
    checks++; if (bus.trap_type_o !== 2'd0 || bus.redirect_o !== 1'b1) begin errors++; $display("FAIL mret_type type=%0h redir=%0h exp 0 1", bus.trap_type_o, bus.redirect_o); end
    ack();
    read_csr(12'h300, rd);
    checks++; if (rd !== 32'h0000_1888) begin errors++; $display("FAIL mret_mstatus got=%h exp=00001888", rd); end
    read_csr(12'h342, rd);
    checks++; if (rd !== 32'h6) begin errors++; $display("FAIL mret_mcause got=%h exp=00000006", rd); end
  endtask

  task automatic test_csr_collide();
    // MIE=1 now; the same-cycle mstatus write of 0 must be dropped
    bus.csr_we_i = 1'b1; bus.csr_addr_i = 12'h300; bus.csr_wdata_i = 32'h0;
    run_event(32'h7000, 32'hDEAD_BEEF, 32'h0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    ack();
    read_csr(12'h300, rd);
    checks++; if (rd !== 32'h0000_1880) begin errors++; $display("FAIL collide_mstatus got=%h exp=00001880", rd); end
    read_csr(12'h343, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL collide_mtval got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    run_event(32'h8000, 32'h1, 32'h0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    bus.csr_we_i = 1'b1; bus.csr_addr_i = 12'h305; bus.csr_wdata_i = 32'hABC0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.redirect_o !== 1'b1 || bus.flush_o !== 1'b1 || bus.stall_o !== 1'b1 || bus.redirect_pc_o !== 32'h200) begin errors++; $display("FAIL hold_%0d redir=%0h flush=%0h stall=%0h pc=%h exp 1 1 1 00000200", i, bus.redirect_o, bus.flush_o, bus.stall_o, bus.redirect_pc_o); end
      tick();
    end
    bus.redirect_ack_i = 1'b1;
    tick();
    bus.redirect_ack_i = 1'b0; bus.csr_we_i = 1'b0;
    read_csr(12'h305, rd);
    checks++; if (rd !== 32'h201) begin errors++; $display("FAIL hold_mtvec got=%h exp=00000201", rd); end
  endtask

  task automatic test_reset_redir();
    run_event(32'h9000, 32'h2, 32'h0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.redirect_o !== 1'b1) begin errors++; $display("FAIL rr_pre got=%0h exp=1", bus.redirect_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.redirect_o !== 1'b0 || bus.flush_o !== 1'b0 || bus.trap_type_o !== 2'd0) begin errors++; $display("FAIL rr_outputs redir=%0h flush=%0h type=%0h exp 0 0 0", bus.redirect_o, bus.flush_o, bus.trap_type_o); end
    read_csr(12'h341, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rr_mepc got=%h exp=00000000", rd); end
    read_csr(12'h305, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rr_mtvec got=%h exp=00000000", rd); end
    read_csr(12'h304, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rr_mie got=%h exp=00000000", rd); end
    read_csr(12'h343, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rr_mtval got=%h exp=00000000", rd); end
    write_csr(12'h341, 32'h1003);
    read_csr(12'h341, rd);
    checks++; if (rd !== 32'h1000) begin errors++; $display("FAIL mepc_align got=%h exp=00001000", rd); end
    write_csr(12'h123, 32'h5555);
    read_csr(12'h300, rd);
    checks++; if (rd !== 32'h0000_1800) begin errors++; $display("FAIL unowned_write mstatus=%h exp=00001800", rd); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    bus.csr_addr_i = 12'h0;
    test_reset();
    test_illegal();
    test_irq();
    test_priority();
    test_mret();
    test_csr_collide();
    test_back_to_back();
    test_reset_redir();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
